// File: rtl/pgr_apb_regbank_32bit.sv
// APB-style target register bank: eight byte-writable control registers, status sample,
// free-running cycle counter, ID word and scratch, serviced by a wait-state access FSM.
module pgr_apb_regbank_32bit #(
    parameter logic [3:0]  WAIT_CYC = 4'd2,
    parameter logic [31:0] ID_VALUE = 32'h5047_0100,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         p_sel,
    input  logic [3:0]   p_strb,
    input  logic [15:0]  p_addr,
    input  logic [31:0]  p_wdata,
    input  logic         p_ce,
    input  logic         p_we,
    output logic         p_rdy,
    output logic [31:0]  p_rdata,
    input  logic [31:0]  status_in,
    output logic [255:0] ctrl_out,
    output logic [7:0]   ctrl_wr_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               commit_s;
    logic [3:0]         wcnt_r;
    logic [13:0]        addr_r;
    logic               we_r;
    logic [3:0]         strb_r;
    logic [31:0]        wdata_r;
    logic [13:0]        rd_addr_s;
    logic [31:0]        rd_val_s;
    logic [7:0][31:0]   ctrl_r;
    logic [31:0]        scratch_r;
    logic [31:0]        status_r;
    logic [31:0]        cycle_r;
    logic               p_rdy_r;
    logic [31:0]        p_rdata_r;
    logic [7:0]         pulse_r;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Access FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (p_sel && p_ce) begin
                    accept_s = 1'b1;
                    if (WAIT_CYC == 4'd0) begin
                        state_nxt_s = ST_ACK;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!(p_sel && p_ce)) begin
                    state_nxt_s = ST_IDLE;
                end else if (wcnt_r == (WAIT_CYC - 4'd1)) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACK:  state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (!p_ce || !p_sel) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign commit_s  = (state_r == ST_ACK) && we_r;
    // With zero wait states the read is sampled in the accept cycle, before addr_r is loaded.
    assign rd_addr_s = (state_r == ST_IDLE) ? p_addr[15:2] : addr_r;

    // Read-data multiplexer over the address map
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (rd_addr_s[13:4] != 10'd0) begin
            rd_val_s = 32'h0000_0000;
        end else begin
            case (rd_addr_s[3:0])
                4'd0, 4'd1, 4'd2, 4'd3,
                4'd4, 4'd5, 4'd6, 4'd7: rd_val_s = ctrl_r[rd_addr_s[2:0]];
                4'd8:    rd_val_s = status_r;
                4'd9:    rd_val_s = cycle_r;
                4'd10:   rd_val_s = ID_VALUE;
                4'd11:   rd_val_s = scratch_r;
                default: rd_val_s = 32'h0000_0000;
            endcase
        end
    end

    // FSM state, wait counter and access latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wcnt_r  <= 4'd0;
            addr_r  <= 14'd0;
            we_r    <= 1'b0;
            strb_r  <= 4'd0;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                wcnt_r  <= 4'd0;
                addr_r  <= p_addr[15:2];
                we_r    <= p_we;
                strb_r  <= p_strb;
                wdata_r <= p_wdata;
            end else if (state_r == ST_WAIT) begin
                wcnt_r <= wcnt_r + 4'd1;
            end
        end
    end

    // Writable register commit and per-register write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r    <= {8{CTRL_RST}};
            scratch_r <= 32'h0000_0000;
            pulse_r   <= 8'h00;
        end else begin
            pulse_r <= 8'h00;
            if (commit_s && (addr_r[13:4] == 10'd0)) begin
                if (addr_r[3] == 1'b0) begin
                    ctrl_r[addr_r[2:0]]  <= byte_merge(ctrl_r[addr_r[2:0]], wdata_r, strb_r);
                    pulse_r[addr_r[2:0]] <= 1'b1;
                end else if (addr_r[3:0] == 4'd11) begin
                    scratch_r <= byte_merge(scratch_r, wdata_r, strb_r);
                end
            end
        end
    end

    // Status sample and cycle counter; a clear wins over the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= 32'h0000_0000;
            cycle_r  <= 32'h0000_0000;
        end else begin
            status_r <= status_in;
            if (commit_s && (addr_r == 14'd9)) begin
                cycle_r <= 32'h0000_0000;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
        end
    end

    // Registered bus response, loaded on the edge that enters ACK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rdy_r   <= 1'b0;
            p_rdata_r <= 32'h0000_0000;
        end else begin
            p_rdy_r   <= (state_nxt_s == ST_ACK);
            p_rdata_r <= (state_nxt_s == ST_ACK) ? rd_val_s : 32'h0000_0000;
        end
    end

    assign p_rdy         = p_rdy_r;
    assign p_rdata       = p_rdata_r;
    assign ctrl_out      = ctrl_r;
    assign ctrl_wr_pulse = pulse_r;

endmodule
